// File: rtl/ddram_avl_bridge.sv
// ============================================================================
//  Module      : ddram_avl_bridge
//  Description : Bridges the single-requestor DDRAM read/write request port
//                onto an Avalon-MM host (reads burst, writes single beat).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddram_avl_bridge (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [28:0] rd_addr,
    input  logic [7:0]  rd_burstcnt,
    input  logic        rd_req,
    output logic        rd_ack,
    output logic [63:0] rd_data,
    output logic        rd_data_valid,

    input  logic [28:0] wr_addr,
    input  logic [7:0]  wr_burstcnt,
    input  logic [63:0] wr_data,
    input  logic [7:0]  wr_be,
    input  logic        wr_req,
    output logic        wr_ack,
    output logic        wr_busy,

    output logic [28:0] avl_address,
    output logic [7:0]  avl_burstcount,
    output logic        avl_read,
    output logic        avl_write,
    output logic [63:0] avl_writedata,
    output logic [7:0]  avl_byteenable,
    input  logic        avl_waitrequest,
    input  logic [63:0] avl_readdata,
    input  logic        avl_readdatavalid,

    output logic        stray_rd
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_CMD  = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_CMD  = 3'd3;
    localparam logic [2:0] S_WR_ACK  = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_remain;
    logic       w_wr_burst_unused;

    assign w_wr_burst_unused = |wr_burstcnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (wr_req)
                    w_state_nxt = S_WR_CMD;
                else if (rd_req)
                    w_state_nxt = S_RD_CMD;
            end
            S_RD_CMD: begin
                if (!avl_waitrequest)
                    w_state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                // remain==0 only when the sole beat arrived with command acceptance
                if (r_remain == 8'd0)
                    w_state_nxt = S_IDLE;
                else if (avl_readdatavalid && (r_remain == 8'd1))
                    w_state_nxt = S_IDLE;
            end
            S_WR_CMD: begin
                if (!avl_waitrequest)
                    w_state_nxt = S_WR_ACK;
            end
            S_WR_ACK: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_remain       <= 8'd0;
            rd_ack         <= 1'b0;
            rd_data        <= 64'd0;
            rd_data_valid  <= 1'b0;
            wr_ack         <= 1'b0;
            wr_busy        <= 1'b0;
            avl_address    <= 29'd0;
            avl_burstcount <= 8'd0;
            avl_read       <= 1'b0;
            avl_write      <= 1'b0;
            avl_writedata  <= 64'd0;
            avl_byteenable <= 8'd0;
            stray_rd       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            rd_ack        <= 1'b0;
            rd_data_valid <= 1'b0;
            wr_ack        <= 1'b0;
            wr_busy       <= (w_state_nxt != S_IDLE) || avl_waitrequest;

            case (r_state)
                S_IDLE: begin
                    if (wr_req) begin
                        avl_address    <= wr_addr;
                        avl_writedata  <= wr_data;
                        avl_byteenable <= wr_be;
                        avl_burstcount <= 8'd1;
                        avl_write      <= 1'b1;
                    end else if (rd_req) begin
                        avl_address    <= rd_addr;
                        avl_burstcount <= (rd_burstcnt == 8'd0) ? 8'd1 : rd_burstcnt;
                        avl_read       <= 1'b1;
                    end
                    if (avl_readdatavalid)
                        stray_rd <= 1'b1;
                end
                S_RD_CMD: begin
                    if (!avl_waitrequest) begin
                        avl_read <= 1'b0;
                        rd_ack   <= 1'b1;
                        if (avl_readdatavalid) begin
                            rd_data       <= avl_readdata;
                            rd_data_valid <= 1'b1;
                            r_remain      <= avl_burstcount - 8'd1;
                        end else begin
                            r_remain <= avl_burstcount;
                        end
                    end else if (avl_readdatavalid) begin
                        stray_rd <= 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (avl_readdatavalid) begin
                        if (r_remain != 8'd0) begin
                            rd_data       <= avl_readdata;
                            rd_data_valid <= 1'b1;
                            r_remain      <= r_remain - 8'd1;
                        end else begin
                            stray_rd <= 1'b1;
                        end
                    end
                end
                S_WR_CMD: begin
                    if (!avl_waitrequest) begin
                        avl_write <= 1'b0;
                        wr_ack    <= 1'b1;
                    end
                    if (avl_readdatavalid)
                        stray_rd <= 1'b1;
                end
                default: begin
                    if (avl_readdatavalid)
                        stray_rd <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddram_avl_bridge.sv
// ============================================================================
//  Module      : tb_ddram_avl_bridge
//  Description : Directed self-checking bench for ddram_avl_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddram_avl_bridge;

    logic        clk;
    logic        reset_n;
    logic [28:0] rd_addr;
    logic [7:0]  rd_burstcnt;
    logic        rd_req;
    logic        rd_ack;
    logic [63:0] rd_data;
    logic        rd_data_valid;
    logic [28:0] wr_addr;
    logic [7:0]  wr_burstcnt;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic        wr_req;
    logic        wr_ack;
    logic        wr_busy;
    logic [28:0] avl_address;
    logic [7:0]  avl_burstcount;
    logic        avl_read;
    logic        avl_write;
    logic [63:0] avl_writedata;
    logic [7:0]  avl_byteenable;
    logic        avl_waitrequest;
    logic [63:0] avl_readdata;
    logic        avl_readdatavalid;
    logic        stray_rd;

    int total;
    int bad;

    ddram_avl_bridge dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .rd_addr           (rd_addr),
        .rd_burstcnt       (rd_burstcnt),
        .rd_req            (rd_req),
        .rd_ack            (rd_ack),
        .rd_data           (rd_data),
        .rd_data_valid     (rd_data_valid),
        .wr_addr           (wr_addr),
        .wr_burstcnt       (wr_burstcnt),
        .wr_data           (wr_data),
        .wr_be             (wr_be),
        .wr_req            (wr_req),
        .wr_ack            (wr_ack),
        .wr_busy           (wr_busy),
        .avl_address       (avl_address),
        .avl_burstcount    (avl_burstcount),
        .avl_read          (avl_read),
        .avl_write         (avl_write),
        .avl_writedata     (avl_writedata),
        .avl_byteenable    (avl_byteenable),
        .avl_waitrequest   (avl_waitrequest),
        .avl_readdata      (avl_readdata),
        .avl_readdatavalid (avl_readdatavalid),
        .stray_rd          (stray_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag vector order: {avl_read, avl_write, rd_ack, rd_data_valid, wr_ack, wr_busy, stray_rd}
    task automatic test_reset;
        total++;
        if ({avl_read, avl_write, rd_ack, rd_data_valid, wr_ack, wr_busy, stray_rd} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=%b",
                     {avl_read, avl_write, rd_ack, rd_data_valid, wr_ack, wr_busy, stray_rd}, 7'b0);
        end
        total++;
        if ({avl_address, avl_burstcount, avl_byteenable} !== 45'd0) begin
            bad++;
            $display("FAIL reset_cmd got=%h exp=0", {avl_address, avl_burstcount, avl_byteenable});
        end
        total++;
        if ({rd_data, avl_writedata} !== 128'd0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {rd_data, avl_writedata});
        end
    endtask

    task automatic test_read_burst;
        logic [63:0] exp;
        rd_addr = 29'h100; rd_burstcnt = 8'd4; rd_req = 1'b1;
        @(negedge clk);
        total++;
        if ({avl_read, avl_address, avl_burstcount, rd_ack} !== {1'b1, 29'h100, 8'd4, 1'b0}) begin
            bad++;
            $display("FAIL rb_cmd got=%h exp=%h", {avl_read, avl_address, avl_burstcount, rd_ack},
                     {1'b1, 29'h100, 8'd4, 1'b0});
        end
        @(negedge clk);
        total++;
        if ({avl_read, rd_ack, rd_data_valid} !== 3'b010) begin
            bad++;
            $display("FAIL rb_ack got=%b exp=010", {avl_read, rd_ack, rd_data_valid});
        end
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = 64'h1111_2222_0000_0000 + 64'(i);
            avl_readdatavalid = 1'b1; avl_readdata = exp;
            @(negedge clk);
            total++;
            if ({rd_data_valid, rd_ack, rd_data} !== {1'b1, 1'b0, exp}) begin
                bad++;
                $display("FAIL rb_beat%0d got=%h exp=%h", i, {rd_data_valid, rd_ack, rd_data},
                         {1'b1, 1'b0, exp});
            end
        end
        avl_readdatavalid = 1'b0;
        @(negedge clk);
        total++;
        if ({rd_data_valid, avl_read, wr_busy, stray_rd} !== 4'b0000) begin
            bad++;
            $display("FAIL rb_idle got=%b exp=0000", {rd_data_valid, avl_read, wr_busy, stray_rd});
        end
    endtask

    task automatic test_wr_stall;
        wr_addr = 29'h20; wr_data = 64'hDEADBEEF_01234567; wr_be = 8'hFF;
        wr_burstcnt = 8'd5; wr_req = 1'b1; avl_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({avl_write, avl_read, avl_address, avl_burstcount, avl_writedata, avl_byteenable,
                 wr_busy, wr_ack} !==
                {1'b1, 1'b0, 29'h20, 8'd1, 64'hDEADBEEF_01234567, 8'hFF, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL ws_hold%0d got=%h exp=%h", i,
                         {avl_write, avl_read, avl_address, avl_burstcount, avl_writedata,
                          avl_byteenable, wr_busy, wr_ack},
                         {1'b1, 1'b0, 29'h20, 8'd1, 64'hDEADBEEF_01234567, 8'hFF, 1'b1, 1'b0});
            end
            if (i == 3) avl_waitrequest = 1'b0;
        end
        @(negedge clk);
        total++;
        if ({wr_ack, avl_write, wr_busy} !== 3'b101) begin
            bad++;
            $display("FAIL ws_ack got=%b exp=101", {wr_ack, avl_write, wr_busy});
        end
        wr_req = 1'b0;
        @(negedge clk);
        total++;
        if ({wr_ack, avl_write, wr_busy} !== 3'b000) begin
            bad++;
            $display("FAIL ws_idle got=%b exp=000", {wr_ack, avl_write, wr_busy});
        end
    endtask

    task automatic test_simultaneous;
        wr_addr = 29'h40; wr_data = 64'h0000_0000_CAFE_F00D; wr_be = 8'h0F; wr_req = 1'b1;
        rd_addr = 29'h80; rd_burstcnt = 8'd1; rd_req = 1'b1;
        @(negedge clk);
        total++;
        if ({avl_write, avl_read, avl_address, avl_byteenable} !== {1'b1, 1'b0, 29'h40, 8'h0F}) begin
            bad++;
            $display("FAIL sim_wcmd got=%h exp=%h", {avl_write, avl_read, avl_address, avl_byteenable},
                     {1'b1, 1'b0, 29'h40, 8'h0F});
        end
        @(negedge clk);
        total++;
        if ({wr_ack, rd_ack, avl_read} !== 3'b100) begin
            bad++;
            $display("FAIL sim_wack got=%b exp=100", {wr_ack, rd_ack, avl_read});
        end
        wr_req = 1'b0;
        @(negedge clk);
        total++;
        if ({wr_ack, rd_ack, avl_read, avl_write} !== 4'b0000) begin
            bad++;
            $display("FAIL sim_gap got=%b exp=0000", {wr_ack, rd_ack, avl_read, avl_write});
        end
        @(negedge clk);
        total++;
        if ({avl_read, avl_address, avl_burstcount, wr_ack} !== {1'b1, 29'h80, 8'd1, 1'b0}) begin
            bad++;
            $display("FAIL sim_rcmd got=%h exp=%h", {avl_read, avl_address, avl_burstcount, wr_ack},
                     {1'b1, 29'h80, 8'd1, 1'b0});
        end
        @(negedge clk);
        total++;
        if ({rd_ack, wr_ack, avl_read} !== 3'b100) begin
            bad++;
            $display("FAIL sim_rack got=%b exp=100", {rd_ack, wr_ack, avl_read});
        end
        rd_req = 1'b0;
        avl_readdatavalid = 1'b1; avl_readdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        avl_readdatavalid = 1'b0;
        total++;
        if ({rd_data_valid, rd_ack, wr_ack, rd_data} !== {3'b100, 64'h0123_4567_89AB_CDEF}) begin
            bad++;
            $display("FAIL sim_beat got=%h exp=%h", {rd_data_valid, rd_ack, wr_ack, rd_data},
                     {3'b100, 64'h0123_4567_89AB_CDEF});
        end
        @(negedge clk);
        total++;
        if ({rd_data_valid, rd_ack, wr_ack, avl_read, avl_write} !== 5'b00000) begin
            bad++;
            $display("FAIL sim_idle got=%b exp=00000", {rd_data_valid, rd_ack, wr_ack, avl_read, avl_write});
        end
    endtask

    task automatic test_burst_zero;
        rd_addr = 29'h55; rd_burstcnt = 8'd0; rd_req = 1'b1;
        @(negedge clk);
        total++;
        if ({avl_read, avl_address, avl_burstcount} !== {1'b1, 29'h55, 8'd1}) begin
            bad++;
            $display("FAIL bz_cmd got=%h exp=%h", {avl_read, avl_address, avl_burstcount},
                     {1'b1, 29'h55, 8'd1});
        end
        @(negedge clk);
        total++;
        if ({rd_ack, avl_read} !== 2'b10) begin
            bad++;
            $display("FAIL bz_ack got=%b exp=10", {rd_ack, avl_read});
        end
        rd_req = 1'b0;
        avl_readdatavalid = 1'b1; avl_readdata = 64'h5555_AAAA_5555_AAAA;
        @(negedge clk);
        avl_readdatavalid = 1'b0;
        total++;
        if ({rd_data_valid, rd_ack, rd_data} !== {2'b10, 64'h5555_AAAA_5555_AAAA}) begin
            bad++;
            $display("FAIL bz_beat got=%h exp=%h", {rd_data_valid, rd_ack, rd_data},
                     {2'b10, 64'h5555_AAAA_5555_AAAA});
        end
        @(negedge clk);
        total++;
        if ({rd_data_valid, rd_ack, wr_busy, stray_rd} !== 4'b0000) begin
            bad++;
            $display("FAIL bz_idle got=%b exp=0000", {rd_data_valid, rd_ack, wr_busy, stray_rd});
        end
    endtask

    task automatic test_ack_coincide;
        rd_addr = 29'h66; rd_burstcnt = 8'd1; rd_req = 1'b1;
        @(negedge clk);
        avl_readdatavalid = 1'b1; avl_readdata = 64'hFEED_FACE_0000_0001;
        @(negedge clk);
        avl_readdatavalid = 1'b0; rd_req = 1'b0;
        total++;
        if ({rd_ack, rd_data_valid, rd_data} !== {2'b11, 64'hFEED_FACE_0000_0001}) begin
            bad++;
            $display("FAIL ac_both got=%h exp=%h", {rd_ack, rd_data_valid, rd_data},
                     {2'b11, 64'hFEED_FACE_0000_0001});
        end
        @(negedge clk);
        total++;
        if ({rd_ack, rd_data_valid, wr_busy, avl_read, stray_rd} !== 5'b00000) begin
            bad++;
            $display("FAIL ac_idle got=%b exp=00000", {rd_ack, rd_data_valid, wr_busy, avl_read, stray_rd});
        end
    endtask

    task automatic test_reset_mid_burst;
        rd_addr = 29'h200; rd_burstcnt = 8'd8; rd_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (rd_ack !== 1'b1) begin
            bad++;
            $display("FAIL rm_ack got=%b exp=1", rd_ack);
        end
        rd_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            avl_readdatavalid = 1'b1; avl_readdata = 64'hB000 + 64'(i);
            @(negedge clk);
            total++;
            if ({rd_data_valid, rd_data, stray_rd} !== {1'b1, 64'hB000 + 64'(i), 1'b0}) begin
                bad++;
                $display("FAIL rm_beat%0d got=%h exp=%h", i, {rd_data_valid, rd_data, stray_rd},
                         {1'b1, 64'hB000 + 64'(i), 1'b0});
            end
        end
        avl_readdatavalid = 1'b0;
        reset_n = 1'b0;
        #1;
        total++;
        if ({avl_read, rd_ack, rd_data_valid, wr_busy, stray_rd, rd_data} !== {5'b0, 64'd0}) begin
            bad++;
            $display("FAIL rm_async got=%h exp=0", {avl_read, rd_ack, rd_data_valid, wr_busy, stray_rd, rd_data});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            avl_readdatavalid = 1'b1; avl_readdata = 64'hC000 + 64'(i);
            @(negedge clk);
            total++;
            if ({rd_data_valid, rd_ack, avl_read} !== 3'b000) begin
                bad++;
                $display("FAIL rm_late%0d got=%b exp=000", i, {rd_data_valid, rd_ack, avl_read});
            end
        end
        avl_readdatavalid = 1'b0;
        total++;
        if (stray_rd !== 1'b1) begin
            bad++;
            $display("FAIL rm_stray got=%b exp=1", stray_rd);
        end
        rd_addr = 29'h300; rd_burstcnt = 8'd1; rd_req = 1'b1;
        @(negedge clk);
        total++;
        if ({avl_read, avl_address, avl_burstcount} !== {1'b1, 29'h300, 8'd1}) begin
            bad++;
            $display("FAIL rm_next_cmd got=%h exp=%h", {avl_read, avl_address, avl_burstcount},
                     {1'b1, 29'h300, 8'd1});
        end
        @(negedge clk);
        rd_req = 1'b0;
        total++;
        if (rd_ack !== 1'b1) begin
            bad++;
            $display("FAIL rm_next_ack got=%b exp=1", rd_ack);
        end
        avl_readdatavalid = 1'b1; avl_readdata = 64'hD00D;
        @(negedge clk);
        avl_readdatavalid = 1'b0;
        total++;
        if ({rd_data_valid, rd_data, stray_rd} !== {1'b1, 64'hD00D, 1'b1}) begin
            bad++;
            $display("FAIL rm_next_beat got=%h exp=%h", {rd_data_valid, rd_data, stray_rd},
                     {1'b1, 64'hD00D, 1'b1});
        end
    endtask

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0;
        rd_addr = '0; rd_burstcnt = '0; rd_req = 1'b0;
        wr_addr = '0; wr_burstcnt = '0; wr_data = '0; wr_be = '0; wr_req = 1'b0;
        avl_waitrequest = 1'b0; avl_readdata = '0; avl_readdatavalid = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_read_burst();
        test_wr_stall();
        test_simultaneous();
        test_burst_zero();
        test_ack_coincide();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ddram_avl_bridge.md
DDRAM_AVL_BRIDGE -- requirements
Module: ddram_avl_bridge

Interface
REQ-001 SHALL expose ports: clk  in  1  sole clock, all logic rising-edge.
REQ-002 SHALL expose: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL expose: rd_addr  in  29 / rd_burstcnt  in  8 / rd_req  in  1  (level, held until rd_ack) / rd_ack  out  1 / rd_data  out  64 / rd_data_valid  out  1.
REQ-004 SHALL expose: wr_addr  in  29 / wr_burstcnt  in  8 / wr_data  in  64 / wr_be  in  8 / wr_req  in  1  (level, held until wr_ack) / wr_ack  out  1 / wr_busy  out  1.
REQ-005 SHALL expose Avalon-MM host: avl_address  out  29 / avl_burstcount  out  8 / avl_read  out  1 / avl_write  out  1 / avl_writedata  out  64 / avl_byteenable  out  8 / avl_waitrequest  in  1 / avl_readdata  in  64 / avl_readdatavalid  in  1.
REQ-006 SHALL expose: stray_rd  out  1  sticky flag, readdatavalid received with no read outstanding.
REQ-007 The block SHALL be the responder end of the single-requestor DDRAM request interface (the rd_*/wr_* port set driven by the DDRAM arbiter), bridging it onto the DDRAM Avalon port.

Function
REQ-008 SHALL implement states IDLE, RD_CMD, RD_DATA, WR_CMD, WR_ACK; all Avalon and upstream outputs SHALL be registered.
REQ-009 IDLE: wr_req high -> latch wr_addr/wr_data/wr_be, set avl_write=1, avl_burstcount=1, go WR_CMD; write SHALL win if wr_req and rd_req are both high.
REQ-010 IDLE: rd_req high and wr_req low -> latch rd_addr, latch burst = rd_burstcnt (0 clamped to 1), set avl_read=1, avl_burstcount=burst, go RD_CMD.
REQ-011 RD_CMD/WR_CMD: avl_address, avl_burstcount, avl_writedata, avl_byteenable and avl_read/avl_write SHALL stay stable while avl_waitrequest=1.
REQ-012 RD_CMD with avl_waitrequest=0: clear avl_read, load 8-bit remain=burst, go RD_DATA; rd_ack SHALL be 1 for exactly the first RD_DATA cycle.
REQ-013 RD_DATA: each avl_readdatavalid SHALL produce, next cycle, rd_data=avl_readdata and rd_data_valid=1, and decrement remain; when remain==1 and a beat is received -> IDLE.
REQ-014 The first data beat MAY coincide with rd_ack (readdatavalid in the acceptance cycle's successor); both SHALL be asserted together in that case.
REQ-015 WR_CMD with avl_waitrequest=0: clear avl_write, go WR_ACK; WR_ACK SHALL assert wr_ack=1 for one cycle, then go IDLE.
REQ-016 wr_burstcnt SHALL be ignored; every write is a single beat (avl_burstcount=1).
REQ-017 rd_req/wr_req SHALL be ignored outside IDLE; the ack cycle is never IDLE, so a requestor dropping req the cycle after ack is never double-accepted.
REQ-018 wr_busy SHALL be 1 whenever state != IDLE or avl_waitrequest=1.
REQ-019 avl_readdatavalid outside RD_DATA SHALL NOT assert rd_data_valid and SHALL set stray_rd=1 (held until reset).
REQ-020 Requestors SHALL see at most one ack per accepted request; no read or write SHALL be issued while a read burst remains outstanding.

Reset
REQ-021 reset_n=0 SHALL immediately force state IDLE, remain=0 and all outputs (avl_read, avl_write, rd_ack, rd_data_valid, wr_ack, wr_busy, stray_rd, address/data/burst regs) to 0, regardless of activity.
REQ-022 A transaction interrupted by reset SHALL be abandoned; its late readdatavalid beats SHALL be handled per REQ-019.

Verification
REQ-023 Read burst: rd_req, rd_addr=0x100, rd_burstcnt=4, waitrequest low -> avl_read one cycle at 0x100/burst 4, rd_ack one cycle, exactly 4 rd_data_valid beats in order, return IDLE.
REQ-024 Waitrequest stall: write to 0x20 with data 0xDEADBEEF_01234567, be=0xFF, waitrequest high 3 cycles -> avl_write held stable 4 cycles, wr_busy=1 throughout, wr_ack one cycle after acceptance.
REQ-025 Simultaneous rd_req and wr_req in IDLE -> write issued first, wr_ack, then read issued; each ack exactly once.
REQ-026 rd_burstcnt=0 -> avl_burstcount=1, one beat returned, rd_ack once.
REQ-027 Ack coincidence: readdatavalid in cycle immediately after acceptance, burst 1 -> rd_ack and rd_data_valid both 1 same cycle, IDLE next cycle.
REQ-028 Reset mid-burst: reset_n low after 2 of 8 beats, released, 6 more readdatavalid -> no rd_data_valid, stray_rd=1, next rd_req serviced normally.
